// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and RAM-side bus bundle for mem_access_unit
//
// Purpose: groups the CPU request handshake and the RAM strobe/address/data
// signals driven or observed by mem_access_unit.
// Modports:
//   master - requester side (control unit + RAM): drives start, rw, cpu_addr,
//            cpu_wdata, mem_dout; observes everything else.
//   slave  - mem_access_unit: drives busy, done, rdata, addr_err, mem_read,
//            mem_write, mem_addr, mem_din.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  rw;
    logic [31:0]           cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  addr_err;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (
        output start, rw, cpu_addr, cpu_wdata, mem_dout,
        input  busy, done, rdata, addr_err, mem_read, mem_write, mem_addr, mem_din
    );

    modport slave (
        input  start, rw, cpu_addr, cpu_wdata, mem_dout,
        output busy, done, rdata, addr_err, mem_read, mem_write, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single load/store sequencer for the 512x32 word RAM
//
// Purpose: accepts one load/store request at a time, drives the RAM's
// level-sensitive Read/Write strobe after one address-setup cycle, holds it
// for WAIT_CYCLES+1 cycles, captures load data into rdata and pulses done.
// Ports:
//   clock - rising-edge system clock
//   clear - synchronous active-high reset, highest priority
//   bus   - mem_access_unit_if.slave: start/rw/cpu_addr/cpu_wdata request in,
//           busy/done/rdata/addr_err status out, mem_read/mem_write/mem_addr/
//           mem_din to the RAM, mem_dout from the RAM
module mem_access_unit #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input logic               clock,
    input logic               clear,
    mem_access_unit_if.slave  bus
);

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_rw;
    logic [3:0]            r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_addr_err;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_din;
    logic [DATA_WIDTH-1:0] r_rdata;

    // Any address bit above the RAM range is an error; there is no wrap.
    logic w_addr_oor;
    assign w_addr_oor = |bus.cpu_addr[31:ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_rw        <= 1'b0;
            r_cnt       <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr_err  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_rw       <= bus.rw;
                        r_mem_addr <= bus.cpu_addr[ADDR_WIDTH-1:0];
                        r_mem_din  <= bus.cpu_wdata;
                        r_busy     <= 1'b1;
                        if (w_addr_oor) begin
                            // Skip the RAM entirely; done goes high next cycle.
                            r_addr_err <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_addr_err <= 1'b0;
                            r_state    <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    r_mem_write <= r_rw;
                    r_mem_read  <= ~r_rw;
                    r_cnt       <= LP_WAIT;
                    r_state     <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        // Strobe has been high WAIT_CYCLES+1 cycles; RAM output is valid.
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b0;
                        if (!r_rw) begin
                            r_rdata <= bus.mem_dout;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rdata     = r_rdata;
    assign bus.addr_err  = r_addr_err;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_din   = r_mem_din;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit (WAIT_CYCLES 1, 0, 15)
module tb_mem_access_unit;

    logic clk;
    logic clear;

    logic [2:0]  start_v;
    logic [2:0]  rw_v;
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  err_v;
    logic [2:0]  rd_v;
    logic [2:0]  wr_v;
    logic [31:0] rdata_v [3];
    logic [8:0]  maddr_v [3];
    logic [31:0] mdin_v  [3];

    logic [31:0] ram    [3][512];
    logic [31:0] shadow [3][512];
    logic [31:0] cur_rd [3];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          done_cyc;
        int          swidth;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_access_unit_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) u_if ();

        assign u_if.start     = start_v[g];
        assign u_if.rw        = rw_v[g];
        assign u_if.cpu_addr  = addr_v[g];
        assign u_if.cpu_wdata = wdata_v[g];
        assign u_if.mem_dout  = ram[g][u_if.mem_addr];
        assign busy_v[g]      = u_if.busy;
        assign done_v[g]      = u_if.done;
        assign err_v[g]       = u_if.addr_err;
        assign rd_v[g]        = u_if.mem_read;
        assign wr_v[g]        = u_if.mem_write;
        assign rdata_v[g]     = u_if.rdata;
        assign maddr_v[g]     = u_if.mem_addr;
        assign mdin_v[g]      = u_if.mem_din;

        mem_access_unit #(
            .ADDR_WIDTH (9),
            .DATA_WIDTH (32),
            .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 15))
        ) u_dut (
            .clock(clk),
            .clear(clear),
            .bus  (u_if.slave)
        );
    end

    // RAM model: asynchronous read, write on the clock edge while Write is high.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (wr_v[g]) ram[g][maddr_v[g]] <= mdin_v[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request on instance k and follows it cycle by cycle.
    // Cycle c is the cycle after the c-th clock edge counting the accepting edge as edge 0.
    task automatic run_req(input int k, input logic rw, input logic [31:0] addr,
                           input logic [31:0] wd, input bit poke);
        exp_t       e;
        exp_t       got;
        int         w;
        logic       err;
        logic [8:0] a9;
        int         swidth;
        int         sfirst;
        int         dones;
        int         dcyc;
        int         wrong;
        int         unstable;
        logic       busy1;
        logic       err1;
        int         ncyc;
        w        = wc(k);
        swidth   = 0;
        sfirst   = -1;
        dones    = 0;
        dcyc     = -1;
        wrong    = 0;
        unstable = 0;
        busy1    = 1'b0;
        err1     = 1'b0;
        err      = |addr[31:9];
        a9       = addr[8:0];
        e.err      = err;
        e.done_cyc = err ? 1 : 3 + w;
        e.swidth   = err ? 0 : w + 1;
        e.rdata    = (err || rw) ? cur_rd[k] : shadow[k][a9];
        if (!err) begin
            if (rw) shadow[k][a9] = wd;
            else    cur_rd[k]     = e.rdata;
        end
        sb.push_back(e);
        ncyc = e.done_cyc + 2;

        start_v[k] = 1'b1;
        rw_v[k]    = rw;
        addr_v[k]  = addr;
        wdata_v[k] = wd;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (!poke || c >= 4) begin
                start_v[k] = 1'b0;
            end else begin
                rw_v[k]    = ~rw;
                addr_v[k]  = addr ^ 32'h1;
                wdata_v[k] = ~wd;
            end
            if (c == 1) begin
                busy1 = busy_v[k];
                err1  = err_v[k];
            end
            if (rd_v[k] && wr_v[k]) wrong++;
            if (rw ? rd_v[k] : wr_v[k]) wrong++;
            if (rw ? wr_v[k] : rd_v[k]) begin
                swidth++;
                if (sfirst < 0) sfirst = c;
            end
            if (!err && c <= e.done_cyc && (maddr_v[k] !== a9 || mdin_v[k] !== wd)) unstable++;
            if (done_v[k]) begin
                dones++;
                if (dcyc < 0) begin
                    dcyc = c;
                    if (sb.size() > 0) begin
                        got = sb.pop_front();
                        chk("rdata_at_done", rdata_v[k], got.rdata);
                        chk("addr_err_at_done", {31'd0, err_v[k]}, {31'd0, got.err});
                    end
                end
            end
        end
        if (dcyc < 0 && sb.size() > 0) void'(sb.pop_front());
        chk("done_cycle", dcyc, e.done_cyc);
        chk("done_count", dones, 1);
        chk("strobe_width", swidth, e.swidth);
        chk("strobe_first_cycle", sfirst, (e.swidth > 0) ? 2 : -1);
        chk("wrong_strobe", wrong, 0);
        chk("addr_din_stable", unstable, 0);
        chk("busy_cycle1", {31'd0, busy1}, 32'd1);
        chk("addr_err_cycle1", {31'd0, err1}, {31'd0, err});
        chk("busy_after", {31'd0, busy_v[k]}, 32'd0);
    endtask

    initial begin
        int acc[$];
        logic pb;
        int nd;
        total = 0;
        bad   = 0;
        clear = 1'b1;
        // start held high during reset: clear must win.
        start_v = 3'b111;
        rw_v    = 3'b111;
        for (int k = 0; k < 3; k++) begin
            addr_v[k]  = 32'h5;
            wdata_v[k] = 32'h1111_1111;
            cur_rd[k]  = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy",  {31'd0, busy_v[k]}, 32'd0);
            chk("rst_done",  {31'd0, done_v[k]}, 32'd0);
            chk("rst_err",   {31'd0, err_v[k]},  32'd0);
            chk("rst_read",  {31'd0, rd_v[k]},   32'd0);
            chk("rst_write", {31'd0, wr_v[k]},   32'd0);
            chk("rst_addr",  {23'd0, maddr_v[k]}, 32'd0);
            chk("rst_din",   mdin_v[k],  32'd0);
            chk("rst_rdata", rdata_v[k], 32'd0);
        end
        clear   = 1'b0;
        start_v = 3'b000;
        @(negedge clk);

        run_req(0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0);
        run_req(0, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
        run_req(0, 1'b1, 32'h0000_01FF, 32'h1234_5678, 1'b0);
        run_req(0, 1'b0, 32'h0000_01FF, 32'h0, 1'b0);
        run_req(0, 1'b0, 32'h0000_0200, 32'h0, 1'b0);
        run_req(0, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
        run_req(0, 1'b1, 32'h8000_0005, 32'h5555_AAAA, 1'b0);
        run_req(0, 1'b0, 32'h0000_01FF, 32'h0, 1'b1);

        // start held high for 12 edges: accepts expected at edges 0, 5, 10.
        pb = 1'b0;
        nd = 0;
        start_v[0] = 1'b1;
        rw_v[0]    = 1'b0;
        addr_v[0]  = 32'h5;
        wdata_v[0] = 32'h0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 12) start_v[0] = 1'b0;
            if (busy_v[0] && !pb) acc.push_back(c - 1);
            pb = busy_v[0];
            if (done_v[0]) begin
                nd++;
                chk("stream_rdata", rdata_v[0], 32'hDEAD_BEEF);
            end
        end
        chk("stream_accepts", acc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("stream_accept_cycle", (i < acc.size()) ? acc[i] : -1, i * 5);
        end
        chk("stream_dones", nd, 3);
        cur_rd[0] = 32'hDEAD_BEEF;

        // clear during the strobe of a write: everything drops, no done.
        start_v[0] = 1'b1;
        rw_v[0]    = 1'b1;
        addr_v[0]  = 32'h7;
        wdata_v[0] = 32'hCAFE_F00D;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("abort_write_high", {31'd0, wr_v[0]}, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort_write", {31'd0, wr_v[0]},   32'd0);
        chk("abort_read",  {31'd0, rd_v[0]},   32'd0);
        chk("abort_busy",  {31'd0, busy_v[0]}, 32'd0);
        chk("abort_done",  {31'd0, done_v[0]}, 32'd0);
        chk("abort_rdata", rdata_v[0], 32'd0);
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_v[0]) nd++;
        end
        chk("abort_no_done", nd, 0);
        for (int k = 0; k < 3; k++) cur_rd[k] = 32'd0;
        run_req(0, 1'b0, 32'h0000_0005, 32'h0, 1'b0);

        run_req(1, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 1'b0);
        run_req(1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        run_req(2, 1'b1, 32'h0000_01F0, 32'h0F0F_7777, 1'b0);
        run_req(2, 1'b0, 32'h0000_01F0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
